// File: rtl/red_pitaya_daisy_rx_align.sv
// red_pitaya_daisy_rx_align: fabric word aligner and link trainer
// for the daisy-chain receiver, parallel clock domain.
module red_pitaya_daisy_rx_align #(
  parameter int unsigned       IN_W      = 4,
  parameter int unsigned       WORD_W    = 16,
  parameter logic [WORD_W-1:0] TRAIN_PAT = 16'h00FF,
  parameter int unsigned       LOCK_CNT  = 4,
  parameter int unsigned       LOSS_CNT  = 4,
  localparam int unsigned      OFF_W     = $clog2(WORD_W)
) (
  input  logic              par_clk_i,
  input  logic              par_rstn_i,
  input  logic              en_i,
  input  logic              train_i,
  input  logic [IN_W-1:0]   raw_dat_i,
  output logic [WORD_W-1:0] dat_o,
  output logic              dv_o,
  output logic              trained_o,
  output logic [OFF_W-1:0]  off_o,
  output logic [15:0]       err_cnt_o,
  output logic [2:0]        state_o
);

  localparam int unsigned BEATS = WORD_W / IN_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SR_W  = 2 * WORD_W;

  localparam logic [BW-1:0]    BEAT_LAST = BW'(BEATS - 1);
  localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(WORD_W - 1);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_N    = 4'(LOSS_CNT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q;
  logic [BW-1:0]       beat_q;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [3:0]          match_q, match_d;
  logic [3:0]          miss_q, miss_d;
  logic [15:0]         err_q, err_d;
  logic                wcnt_q, wcnt_d;
  logic [WORD_W-1:0]   dat_q, dat_d;
  logic                dv_q, dv_d;
  logic [1:0]          sync_q;

  logic                trn;
  logic                strobe;
  logic [WORD_W-1:0]   cand;
  logic                hit;

  assign trn    = sync_q[1];
  assign strobe = (beat_q == BEAT_LAST);
  assign cand   = sr_q[off_q +: WORD_W];
  assign hit    = (cand == TRAIN_PAT);

  // two-flop synchronizer for the asynchronous training request
  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], train_i};
    end
  end

  // next state: search, slip, settle, lock and loss detection
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    dat_d   = dat_q;
    dv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trn) begin
          state_d = CHECK;
          match_d = '0;
        end
      end
      CHECK: begin
        if (!trn) begin
          state_d = IDLE;
        end else if (strobe) begin
          if (hit) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d = SLIP;
          end
        end
      end
      SLIP: begin
        off_d   = (off_q == OFF_LAST) ? '0
                : off_q + OFF_W'(1);
        match_d = '0;
        wcnt_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!trn) begin
          state_d = IDLE;
        end else if (strobe) begin
          if (wcnt_q) begin
            state_d = CHECK;
          end else begin
            wcnt_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (strobe) begin
          if (trn) begin
            if (!hit) begin
              err_d  = (err_q == 16'hFFFF) ? err_q
                     : err_q + 16'd1;
              miss_d = miss_q + 4'd1;
              if (miss_q + 4'd1 == LOSS_N) begin
                state_d = SLIP;
              end
            end else begin
              miss_d = '0;
            end
          end else begin
            dat_d = cand;
            dv_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath and state registers; enable low clears everything
  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      beat_q  <= '0;
      off_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      wcnt_q  <= 1'b0;
      dat_q   <= '0;
      dv_q    <= 1'b0;
    end else if (!en_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      beat_q  <= '0;
      off_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      wcnt_q  <= 1'b0;
      dat_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= {sr_q[SR_W-IN_W-1:0], raw_dat_i};
      beat_q  <= strobe ? '0 : beat_q + BW'(1);
      off_q   <= off_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      dat_q   <= dat_d;
      dv_q    <= dv_d;
    end
  end

  assign dat_o     = dat_q;
  assign dv_o      = dv_q;
  assign trained_o = (state_q == LOCKED);
  assign off_o     = off_q;
  assign err_cnt_o = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_red_pitaya_daisy_rx_align.sv
// tb_red_pitaya_daisy_rx_align: scoreboard bench for the
// daisy-chain word aligner, narrow and wide configurations.
module tb_red_pitaya_daisy_rx_align;

  localparam int NI = 4;
  localparam int NW = 16;
  localparam int NB = 4;
  localparam int WI = 8;
  localparam int WW = 32;
  localparam int WB = 4;
  localparam logic [15:0] NPAT = 16'h00FF;
  localparam logic [31:0] WPAT = 32'h0000FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          en, train;
  logic [NI-1:0] raw;
  logic [NW-1:0] dat;
  logic          dv, trained;
  logic [3:0]    off;
  logic [15:0]   err;
  logic [2:0]    st;

  logic          wen, wtrain;
  logic [WI-1:0] wraw;
  logic [WW-1:0] wdat;
  logic          wdv, wtrained;
  logic [4:0]    woff;
  logic [15:0]   werr;
  logic [2:0]    wst;

  red_pitaya_daisy_rx_align #(
    .IN_W(NI), .WORD_W(NW), .TRAIN_PAT(NPAT),
    .LOCK_CNT(4), .LOSS_CNT(4)
  ) u_dut (
    .par_clk_i(clk), .par_rstn_i(rstn), .en_i(en),
    .train_i(train), .raw_dat_i(raw), .dat_o(dat),
    .dv_o(dv), .trained_o(trained), .off_o(off),
    .err_cnt_o(err), .state_o(st)
  );

  red_pitaya_daisy_rx_align #(
    .IN_W(WI), .WORD_W(WW), .TRAIN_PAT(WPAT),
    .LOCK_CNT(4), .LOSS_CNT(4)
  ) u_wide (
    .par_clk_i(clk), .par_rstn_i(rstn), .en_i(wen),
    .train_i(wtrain), .raw_dat_i(wraw), .dat_o(wdat),
    .dv_o(wdv), .trained_o(wtrained), .off_o(woff),
    .err_cnt_o(werr), .state_o(wst)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int fdiv(input int q, input int w);
    return (q >= 0) ? q / w : -((-q + w - 1) / w);
  endfunction

  // stream sources: word k sits at sr[d +: W] on its strobe
  int ncyc = 0, nd = 5;
  bit nzero = 1'b0;
  logic [15:0] novr [int];
  int wcyc = 0, wd = 19;
  logic [31:0] wovr [int];

  function automatic logic [15:0] nword(input int k);
    if (nzero) return 16'h0;
    if (novr.exists(k)) return novr[k];
    return NPAT;
  endfunction

  function automatic logic [31:0] wword(input int k);
    if (wovr.exists(k)) return wovr[k];
    return WPAT;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) ncyc <= 0;
    else if (!en) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) wcyc <= 0;
    else if (!wen) wcyc <= 0;
    else wcyc <= wcyc + 1;
  end

  always @(negedge clk) begin
    logic [NI-1:0] r;
    logic [WI-1:0] wr;
    logic [15:0] w;
    logic [31:0] ww;
    int p, q, k;
    for (int j = 0; j < NI; j++) begin
      p = (ncyc - (NB - 1)) * NI + j;
      q = p + nd;
      k = fdiv(q, NW);
      w = nword(k);
      r[NI-1-j] = w[NW-1-(q-k*NW)];
    end
    raw = r;
    for (int j = 0; j < WI; j++) begin
      p = (wcyc - (WB - 1)) * WI + j;
      q = p + wd;
      k = fdiv(q, WW);
      ww = wword(k);
      wr[WI-1-j] = ww[WW-1-(q-k*WW)];
    end
    wraw = wr;
  end

  logic [15:0] nexp_q [$];
  logic [31:0] wexp_q [$];
  time nlast = 0;
  time wlast = 0;

  always @(negedge clk) begin
    if (dv) begin
      if (nexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n_dv_unexpected: got dat %0h expected no dv", dat);
      end else begin
        chk("n_dat", 64'(dat), 64'(nexp_q.pop_front()));
      end
      if (nlast != 0 && $time - nlast < 200)
        chk("n_dv_gap", 64'($time - nlast), 64'd40);
      nlast = $time;
    end
  end

  always @(negedge clk) begin
    if (wdv) begin
      if (wexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w_dv_unexpected: got dat %0h expected no dv", wdat);
      end else begin
        chk("w_dat", 64'(wdat), 64'(wexp_q.pop_front()));
      end
      if (wlast != 0 && $time - wlast < 200)
        chk("w_dv_gap", 64'($time - wlast), 64'd40);
      wlast = $time;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, k, n, prev;
    bit seen0, wrapped, tr_seen;
    rstn = 1'b0; en = 1'b1; train = 1'b1;
    wen = 1'b0; wtrain = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(st), 64'd0);
    chk("rst_off", 64'(off), 64'd0);
    chk("rst_trained", 64'(trained), 64'd0);
    chk("rst_dv", 64'(dv), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_wstate", 64'(wst), 64'd0);
    rstn = 1'b1;

    // lock on pattern at bit offset 5
    n = 0;
    while (trained !== 1'b1 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("n_lock1_time", 64'(n < 2000), 64'd1);
    chk("n_lock1_off", 64'(off), 64'd5);
    chk("n_lock1_err", 64'(err), 64'd0);
    chk("n_lock1_state", 64'(st), 64'd4);

    // data mode: two payload words among pattern words
    while (ncyc % 4 != 0) @(negedge clk);
    c = ncyc;
    novr[c/4+2] = 16'h1234;
    novr[c/4+3] = 16'hABCD;
    for (int i = c/4 - 1; i <= c/4 + 6; i++)
      nexp_q.push_back(nword(i));
    train = 1'b0;
    repeat (32) @(negedge clk);
    train = 1'b1;
    repeat (8) @(negedge clk);
    chk("n_data_drained", 64'(nexp_q.size()), 64'd0);

    // one corrupt word while locked and training
    k = ncyc / 4 + 3;
    novr[k] = 16'h0F0F;
    while (ncyc < 4 * k + 12) @(negedge clk);
    chk("n_err1", 64'(err), 64'd1);
    chk("n_err1_locked", 64'(trained), 64'd1);

    // four corrupt words drop lock
    k = ncyc / 4 + 3;
    for (int i = 0; i < 4; i++) novr[k+i] = 16'h0F0F;
    n = 0;
    while (trained !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("n_loss_time", 64'(n < 200), 64'd1);
    repeat (2) @(negedge clk);
    chk("n_loss_off", 64'(off), 64'd6);
    chk("n_loss_err", 64'(err), 64'd5);

    // relock after a full wrap of the offset
    seen0 = 1'b0;
    n = 0;
    while (trained !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
      if (off == 4'd0) seen0 = 1'b1;
    end
    chk("n_lock2_time", 64'(n < 3000), 64'd1);
    chk("n_lock2_off", 64'(off), 64'd5);
    chk("n_lock2_wrap", 64'(seen0), 64'd1);
    chk("n_lock2_err", 64'(err), 64'd5);

    // all-zero input: lose lock, then endless sweep
    nzero = 1'b1;
    n = 0;
    while (trained !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("n_zero_loss", 64'(n < 200), 64'd1);
    chk("n_zero_err", 64'(err), 64'd9);
    prev = int'(off);
    wrapped = 1'b0;
    tr_seen = 1'b0;
    n = 0;
    while (!(wrapped && off == 4'd7) && n < 3000) begin
      @(negedge clk); n++;
      if (trained) tr_seen = 1'b1;
      if (int'(off) != prev) begin
        chk("n_sweep_step", 64'(off), 64'((prev + 1) % 16));
        if (off == 4'd0) wrapped = 1'b1;
        prev = int'(off);
      end
    end
    chk("n_sweep_time", 64'(n < 3000), 64'd1);
    chk("n_sweep_untrained", 64'(tr_seen), 64'd0);

    // disable at offset 7, then restart
    en = 1'b0;
    @(negedge clk);
    chk("dis_dat", 64'(dat), 64'd0);
    chk("dis_dv", 64'(dv), 64'd0);
    chk("dis_trained", 64'(trained), 64'd0);
    chk("dis_off", 64'(off), 64'd0);
    chk("dis_err", 64'(err), 64'd0);
    chk("dis_state", 64'(st), 64'd0);
    en = 1'b1;
    @(negedge clk);
    chk("re_off", 64'(off), 64'd0);
    n = 0;
    while (off != 4'd1 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("re_step", 64'(off), 64'd1);

    // wide configuration at bit offset 19
    wen = 1'b1;
    wtrain = 1'b1;
    n = 0;
    while (wtrained !== 1'b1 && n < 4000) begin
      @(negedge clk); n++;
    end
    chk("w_lock_time", 64'(n < 4000), 64'd1);
    chk("w_lock_off", 64'(woff), 64'd19);
    chk("w_lock_err", 64'(werr), 64'd0);
    chk("w_lock_state", 64'(wst), 64'd4);
    while (wcyc % 4 != 0) @(negedge clk);
    c = wcyc;
    wovr[c/4+2] = 32'hDEADBEEF;
    wovr[c/4+3] = 32'h12345678;
    for (int i = c/4 - 1; i <= c/4 + 6; i++)
      wexp_q.push_back(wword(i));
    wtrain = 1'b0;
    repeat (32) @(negedge clk);
    wtrain = 1'b1;
    repeat (8) @(negedge clk);
    chk("w_data_drained", 64'(wexp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/red_pitaya_daisy_rx_align.md
# red_pitaya_daisy_rx_align

Parametrised word aligner and link trainer for the daisy-chain receiver. It sits in the parallel clock domain directly behind the serial-to-parallel stage and takes `IN_W` raw bits per cycle with an unknown bit phase. It finds word alignment in fabric against a programmable training pattern, so no SERDES bitslip is needed, and declares lock after repeated matches. It then monitors errors while training, drops lock on sustained loss, and delivers aligned `WORD_W`-bit words with a valid strobe.

## Interface
- `IN_W`, 4: raw bits per clock; `WORD_W` must be an integer multiple.
- `WORD_W`, 16: output word width; 8..64.
- `TRAIN_PAT`, 16'h00FF: training word, `WORD_W` bits.
- `LOCK_CNT`, 4: consecutive matching words required to declare lock; 1..15.
- `LOSS_CNT`, 4: consecutive mismatching words, while locked and training, that drop lock; 1..15.
- `par_clk_i` in 1: parallel clock; the only clock.
- `par_rstn_i` in 1: asynchronous, active-low reset.
- `en_i` in 1: module enable; low forces a synchronous clear.
- `train_i` in 1: training request, asynchronous; passes through an internal 2-flop synchronizer.
- `raw_dat_i` in `IN_W`: raw deserialized bits; MSB is the oldest bit.
- `dat_o` out `WORD_W`: aligned data word.
- `dv_o` out 1: `dat_o` valid, one-cycle pulse per word.
- `trained_o` out 1: link locked.
- `off_o` out `clog2(WORD_W)`: current bit offset.
- `err_cnt_o` out 16: saturating mismatch count while locked and training.
- `state_o` out 3: FSM state; IDLE=0, CHECK=1, SLIP=2, WAIT=3, LOCKED=4.

## Operation
- Let `BEATS = WORD_W/IN_W`.
- Shift register: `sr` is `2*WORD_W` bits and shifts every cycle: `sr <= {sr[2*WORD_W-IN_W-1:0], raw_dat_i}`. The newest bits are in the LSBs.
- Beat counter: `beat` counts 0..`BEATS-1` and wraps. It is free-running while `en_i` is high.
- Strobe: a strobe cycle is any cycle with `beat==BEATS-1`.
- Candidate word: `cand = sr[off +: WORD_W]`, taken from the registered `sr`.
- Sync: `trn` is `train_i` after the 2-flop synchronizer.
- IDLE:
  - `off`, `match_cnt` and `miss_cnt` hold their values.
  - Go to CHECK when `en_i && trn`, clearing `match_cnt`.
- CHECK, evaluated on strobe cycles:
  - `cand==TRAIN_PAT` increments `match_cnt`. Go to LOCKED when `match_cnt` reaches `LOCK_CNT`.
  - A mismatch goes to SLIP.
  - `!trn` returns to IDLE.
- SLIP, one cycle:
  - `off <= (off==WORD_W-1) ? 0 : off+1`.
  - Clear `match_cnt` and go to WAIT.
- WAIT:
  - Discard the next 2 strobes, then go to CHECK.
  - `!trn` returns to IDLE.
- LOCKED with `trn=1`:
  - Each strobe compares `cand` with `TRAIN_PAT`.
  - A mismatch increments `err_cnt` (saturating at 16'hFFFF) and `miss_cnt`.
  - A match clears `miss_cnt`.
  - When `miss_cnt` reaches `LOSS_CNT`, go to SLIP and clear `trained_o`.
- LOCKED with `trn=0`:
  - Each strobe registers `dat_o<=cand` and `dv_o<=1`.
  - No loss detection is done.
  - `off` is frozen.
- `trained_o` is 1 only in LOCKED.
- `dv_o` is 0 in every other state, and also in LOCKED while `trn=1`.
- Same-cycle `en_i` low and strobe: the clear wins.
- Mismatch on the strobe that would reach `LOCK_CNT`: counts as a mismatch and goes to SLIP.

## Timing
- Reset values (`par_rstn_i` low, asynchronous, or `en_i` low, synchronous):
  - `sr`, `beat`, `off`, all counters, `dat_o` and `err_cnt_o` are 0.
  - `dv_o` and `trained_o` are 0.
  - `state_o` is IDLE.
- `train_i` to `trn`: 2 cycles.
- `dat_o`/`dv_o` are registered; they assert in the cycle after the strobe cycle.
- `dv_o` cadence in LOCKED data mode: exactly one pulse every `BEATS` cycles.
- Bit delay: a stream delayed by `d` bits (`0≤d<WORD_W`) relative to strobe-aligned delivery locks at `off==d`.
- Search bound: lock is reached within `WORD_W` slips if the pattern is present. Each slip costs 1 cycle plus 2 discarded words plus `LOCK_CNT` words.
- Exhaustive search: `off` wraps from `WORD_W-1` to 0 and the search continues indefinitely while `trn=1`.
- Reset mid-search or mid-lock: the state is abandoned immediately; there is no residual `dv_o`.

## Test plan
- Lock on delayed pattern: `IN_W=4`, `WORD_W=16`, repeating 16'h00FF delayed 5 bits, `train_i=1` -> `off_o==5`, `trained_o=1` after 4 matching words, `dv_o` stays 0, `err_cnt_o==0`.
- Data after lock: after the lock above, `train_i=0`, send 16'h1234 then 16'hABCD -> `dv_o` pulses 4 cycles apart with `dat_o`=16'h1234, then 16'hABCD.
- Errors and loss: locked and training, corrupt 1 word -> `err_cnt_o==1`, still locked. Then 4 consecutive corrupt words -> `trained_o` falls, `off_o` becomes 6, relock to `off_o==5` after a full wrap.
- No pattern: all-zero input with `train_i=1` -> `off_o` sweeps 0..15, wraps to 0, `trained_o` never rises.
- Disable mid-search: drop `en_i` at `off_o==7` -> next cycle all outputs are 0, `state_o==0`. Re-enable -> search restarts from `off_o==0`.
- Wide configuration: `IN_W=8`, `WORD_W=32`, `TRAIN_PAT`=32'h0000FFFF delayed 19 bits -> lock with `off_o==19`, then `dv_o` every 4 cycles.
